// File: rtl/cp0_timer_irq.sv
// cp0_timer_irq: coprocessor-0 register file with exception/ERET redirect,
// gated interrupt request, external + software interrupt pending bits and a
// prescaled Count/Compare timer.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   writeEnable/number/     mtc0 write strobe, register index, data
//   writeData
//   readData                mfc0 data, combinational from number
//   hasExceptionInPipeline  masks interruptNow while an exception is in flight
//   isException, isBD,      exception (or ERET) presented this cycle, delay-slot
//   exceptionCause,         flag, ExcCode, PC of the excepting instruction and
//   exceptionPC, badVAddr   faulting address for address-error exceptions
//   jump/jumpAddress        combinational fetch redirect and its target
//   interruptNow            interrupt request to the pipeline
//   externalInterrupt       level-sensitive device interrupt lines
//
// mtc0/mfc0 handshake: there is no valid/ready pair. A write takes effect at
// the clock edge where writeEnable is high, unless isException is also high
// in that cycle (the flushed instruction's write is dropped). Reads are purely
// combinational on number.
module cp0_timer_irq #(
  parameter int          NUM_IRQ    = 6,
  parameter int          TIMER_LINE = 15,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0] PRID_VALUE = 32'hDEADBEEF,
  parameter logic        RESET_EXL  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               writeEnable,
  input  logic [4:0]         number,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  input  logic               hasExceptionInPipeline,
  input  logic               isException,
  input  logic               isBD,
  input  logic [4:0]         exceptionCause,
  input  logic [31:0]        exceptionPC,
  input  logic [31:0]        badVAddr,
  output logic               jump,
  output logic [31:0]        jumpAddress,
  output logic               interruptNow,
  input  logic [NUM_IRQ-1:0] externalInterrupt
);

  // ExcCode value the pipeline uses to present an ERET.
  localparam logic [4:0] CAUSE_ERET = 5'h10;
  localparam int         TI_BIT     = TIMER_LINE - 10;
  localparam logic [7:0] PRESC_MAX  = 8'(COUNT_DIV - 1);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  // SR fields
  logic        srIe;
  logic        srExl;
  logic [7:0]  srIm;
  // Cause fields
  logic [4:0]  excCode;
  logic [1:0]  ipSw;
  logic [5:0]  ipHw;
  logic        ti;
  logic        bd;
  // Other registers
  logic [31:0] epc;
  logic [31:0] badVAddrReg;
  logic [31:0] count;
  logic [31:0] compare;
  logic [7:0]  prescaler;

  // Redirect decode
  logic excTake;
  logic eretTake;
  logic wrEn;

  assign excTake  = isException & ~srExl & (exceptionCause != CAUSE_ERET);
  assign eretTake = isException &  srExl & (exceptionCause == CAUSE_ERET);
  assign jump        = excTake | eretTake;
  assign jumpAddress = eretTake ? epc : EXC_VECTOR;

  // Any presented exception flushes the instruction carrying the mtc0.
  assign wrEn = writeEnable & ~isException;

  logic countWr;
  logic compareWr;
  logic srWr;
  logic causeWr;
  logic epcWr;

  assign countWr   = wrEn & (number == REG_COUNT);
  assign compareWr = wrEn & (number == REG_COMPARE);
  assign srWr      = wrEn & (number == REG_SR);
  assign causeWr   = wrEn & (number == REG_CAUSE);
  assign epcWr     = wrEn & (number == REG_EPC);

  // Timer
  logic        presWrap;
  logic [31:0] countInc;
  logic        tiNext;

  assign presWrap = (prescaler == PRESC_MAX);
  assign countInc = count + 32'd1;

  // TI is sticky; a Count write suppresses the increment (and its match),
  // a Compare write clears TI even if the increment matched this edge.
  always_comb begin
    tiNext = ti;
    if (!countWr && presWrap && (countInc == compare)) tiNext = 1'b1;
    if (compareWr) tiNext = 1'b0;
  end

  // Hardware IP bits: unused external lines read 0; TI joins its line using
  // the value it takes at this edge so TI and its IP bit rise together.
  logic [5:0] ipHwNext;
  always_comb begin
    ipHwNext = '0;
    for (int i = 0; i < NUM_IRQ; i++) ipHwNext[i] = externalInterrupt[i];
    ipHwNext[TI_BIT] = ipHwNext[TI_BIT] | tiNext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      srIe        <= 1'b0;
      srExl       <= RESET_EXL;
      srIm        <= 8'hFF;
      excCode     <= '0;
      ipSw        <= '0;
      ipHw        <= '0;
      ti          <= 1'b0;
      bd          <= 1'b0;
      epc         <= '0;
      badVAddrReg <= '0;
      count       <= '0;
      compare     <= 32'hFFFFFFFF;
      prescaler   <= '0;
    end else begin
      ti   <= tiNext;
      ipHw <= ipHwNext;

      if (countWr) begin
        count     <= writeData;
        prescaler <= '0;
      end else if (presWrap) begin
        count     <= countInc;
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + 8'd1;
      end

      if (compareWr) compare <= writeData;

      if (excTake) begin
        srExl   <= 1'b1;
        bd      <= isBD;
        excCode <= exceptionCause;
        epc     <= isBD ? (exceptionPC - 32'd4) : exceptionPC;
        if (exceptionCause == 5'd4 || exceptionCause == 5'd5)
          badVAddrReg <= badVAddr;
      end else if (eretTake) begin
        srExl <= 1'b0;
      end

      if (srWr) begin
        srIe  <= writeData[0];
        srExl <= writeData[1];
        srIm  <= writeData[15:8];
      end
      if (causeWr) ipSw <= writeData[9:8];
      if (epcWr)   epc  <= writeData;
    end
  end

  assign interruptNow = srIe & ~srExl & ~hasExceptionInPipeline &
                        (|({ipHw, ipSw} & srIm));

  always_comb begin
    readData = '0;
    case (number)
      REG_BADVADDR: readData = badVAddrReg;
      REG_COUNT:    readData = count;
      REG_COMPARE:  readData = compare;
      REG_SR:       readData = {16'b0, srIm, 6'b0, srExl, srIe};
      REG_CAUSE:    readData = {bd, ti, 14'b0, ipHw, ipSw, 1'b0, excCode, 2'b0};
      REG_EPC:      readData = epc;
      REG_PRID:     readData = PRID_VALUE;
      default:      readData = '0;
    endcase
  end

endmodule
